ifetch_buffer: RTL and testbench

Instruction-fetch buffer between the PC register and the decode stage of the 32-bit RISC-V pipeline. It consumes fetch addresses from the PC, issues in-order requests to instruction memory, pairs each returned instruction with its PC, and presents `{pc, instr}` to decode through a valid/ready handshake. It also provides backpressure to the PC, `pc_ready` driving the PC's `en`, and discards wrong-path fetches on a branch/jump flush.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/ifetch_buffer_if.sv | 41 ++++
 rtl/ifetch_buffer.sv | 158 +++++++++++++++
 tb/tb_ifetch_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, canonical NOP and the
// fetch-buffer entry layout.
// Contents: XLEN, NOP_INSTR, fetch_entry_t, ptr_width().
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Ring pointer width: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// Fetch-buffer bus: PC request side, instruction-memory request/response and
// the decode-side valid/ready handshake, plus the pipeline flush.
// slave = the fetch buffer itself; master = the surrounding pipeline/memory.
interface ifetch_buffer_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  // PC register side
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;

  // Instruction memory side
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  // Redirect
  logic            flush;

  // Decode side
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  modport slave (
    input  pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           flush, id_ready,
    output pc_ready, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

  modport master (
    output pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           flush, id_ready,
    input  pc_ready, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: issues in-order imem requests for PC fetches,
// pairs each returned instruction with its PC and hands {pc, instr} to decode.
// Ports: clk, rst (sync, active-high), bus (ifetch_buffer_if.slave).
// Latency: request combinational; response in cycle M is visible to decode in
// M+1. Backpressure: pc_ready drops when allocated + queued + to-be-dropped
// entries reach DEPTH; a flush discards everything and drops late responses.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input logic            clk,
  input logic            rst,
  ifetch_buffer_if.slave bus
);

  import riscv_pkg::*;

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  // Ring storage. pc is written at allocation time, instr at fill time, so
  // an entry between alloc_ptr and fill_ptr is "in flight" to memory.
  fetch_entry_t ring [DEPTH];

  ptr_t alloc_ptr;
  ptr_t fill_ptr;
  ptr_t head_ptr;
  ptr_t drop_cnt;
  ptr_t drop_next;

  ptr_t inflight;
  ptr_t queued;
  ptr_t committed;

  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] head_idx;

  logic credit_ok;
  logic req_valid;
  logic push;
  logic rsp_drop;
  logic rsp_keep;
  logic rsp_taken;
  logic id_valid;
  logic pop;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign head_idx  = head_ptr[IW-1:0];

  assign inflight  = alloc_ptr - fill_ptr;
  assign queued    = fill_ptr - head_ptr;

  // Responses still owed for flushed fetches occupy memory-side slots too,
  // so they count against credit. Only registered state is used: a pop in
  // the same cycle does not free a slot until the next cycle, which keeps
  // pc_ready off the id_ready timing path.
  assign committed = alloc_ptr - head_ptr + drop_cnt;
  assign credit_ok = committed < DEPTH_P;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  assign req_valid          = bus.pc_valid & credit_ok & ~bus.flush & ~rst;
  assign push               = req_valid & bus.imem_req_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_ready       = push;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  // Responses for flushed fetches come back first (memory is in order), so
  // while drop_cnt is non-zero every response is stale.
  assign rsp_drop  = bus.imem_rsp_valid & (drop_cnt != '0);
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_keep  = bus.imem_rsp_valid & (drop_cnt == '0) & (inflight != '0) & ~rst;
  assign rsp_taken = rsp_drop | rsp_keep;

  // ---------------------------------------------------------------------------
  // Decode path
  // ---------------------------------------------------------------------------
  assign id_valid     = queued != '0;
  assign pop          = id_valid & bus.id_ready & ~bus.flush;
  assign bus.id_valid = id_valid;
  assign bus.id_instr = id_valid ? XLEN'(ring[head_idx].instr) : XLEN'(NOP_INSTR);
  assign bus.id_pc    = id_valid ? XLEN'(ring[head_idx].pc)    : '0;

  // ---------------------------------------------------------------------------
  // Drop counter
  // ---------------------------------------------------------------------------
  // On flush every in-flight fetch becomes a future drop. A response landing
  // in the flush cycle retires one of them (stale or not, it is discarded).
  always_comb begin
    drop_next = drop_cnt;
    if (bus.flush) begin
      drop_next = drop_cnt + inflight - (rsp_taken ? ONE : '0);
    end else if (rsp_drop) begin
      drop_next = drop_cnt - ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= drop_next;
      if (bus.flush) begin
        // Collapse the ring onto alloc_ptr; push and pop are already
        // suppressed in this cycle.
        head_ptr <= alloc_ptr;
        fill_ptr <= alloc_ptr;
      end else begin
        if (push) begin
          alloc_ptr <= alloc_ptr + ONE;
        end
        if (rsp_keep) begin
          fill_ptr <= fill_ptr + ONE;
        end
        if (pop) begin
          head_ptr <= head_ptr + ONE;
        end
      end
    end
  end

  // Ring contents carry no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ring[alloc_idx].pc <= bus.pc_in;
    end
    if (rsp_keep) begin
      ring[fill_idx].instr <= bus.imem_rsp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> ((inflight != '0) || (drop_cnt != '0)));

  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= DEPTH_P);

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: queue-based reference model of the
// fetch buffer and an in-order memory with per-request latency.
module tb_ifetch_buffer;

  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_buffer_if #(.XLEN(32)) bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Stimulus knobs applied by step()
  logic        d_rst, d_pc_valid, d_req_ready, d_id_ready, d_flush;
  logic [31:0] d_pc_in;
  int          lat_min = 1;
  int          lat_max = 1;

  // Reference model
  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_t;

  fetch_entry_t ready_q [$];   // fetched, waiting for decode
  logic [31:0]  out_q   [$];   // live requests awaiting a response
  int           drop;          // responses owed for flushed requests
  mem_t         mem_q   [$];   // memory pipeline, in order
  int           last_due = 0;
  logic [31:0]  popped_pc [$];

  // Observations / model decisions from the last step
  logic        o_pc_ready, o_req_valid, o_id_valid;
  logic [31:0] o_id_pc, o_id_instr;
  logic        m_accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        e_credit, e_req_valid, e_pc_ready, e_id_valid;
    logic [31:0] e_id_pc, e_id_instr;
    fetch_entry_t ent;
    mem_t m;
    int due;
    rsp_v = 1'b0;
    rsp_d = $urandom();
    if (!d_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = mem_q[0].data;
    end
    rst                = d_rst;
    bus.pc_in          = d_pc_in;
    bus.pc_valid       = d_pc_valid;
    bus.imem_req_ready = d_req_ready;
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_d;
    bus.flush          = d_flush;
    bus.id_ready       = d_id_ready;
    @(negedge clk);

    e_credit    = (ready_q.size() + out_q.size() + drop) < DEPTH;
    e_req_valid = d_pc_valid && e_credit && !d_flush && !d_rst;
    e_pc_ready  = e_req_valid && d_req_ready;
    e_id_valid  = ready_q.size() != 0;
    e_id_pc     = e_id_valid ? ready_q[0].pc    : 32'h0;
    e_id_instr  = e_id_valid ? ready_q[0].instr : NOP_INSTR;

    o_pc_ready  = bus.pc_ready;
    o_req_valid = bus.imem_req_valid;
    o_id_valid  = bus.id_valid;
    o_id_pc     = bus.id_pc;
    o_id_instr  = bus.id_instr;
    m_accepted  = e_pc_ready;

    check("pc_ready", o_pc_ready, e_pc_ready);
    check("imem_req_valid", o_req_valid, e_req_valid);
    if (e_req_valid) check("imem_req_addr", bus.imem_req_addr, d_pc_in);
    check("id_valid", o_id_valid, e_id_valid);
    check("id_pc", o_id_pc, e_id_pc);
    check("id_instr", o_id_instr, e_id_instr);

    if (d_rst) begin
      ready_q.delete();
      out_q.delete();
      mem_q.delete();
      drop     = 0;
      last_due = cyc;
    end else begin
      if (!d_flush && e_id_valid && d_id_ready) begin
        ent = ready_q.pop_front();
        popped_pc.push_back(ent.pc);
      end
      if (rsp_v) begin
        void'(mem_q.pop_front());
        if (drop > 0) drop--;
        else if (out_q.size() > 0) begin
          ent.pc    = out_q.pop_front();
          ent.instr = rsp_d;
          ready_q.push_back(ent);
        end
      end
      if (d_flush) begin
        drop += out_q.size();
        out_q.delete();
        ready_q.delete();
      end
      if (e_pc_ready) begin
        out_q.push_back(d_pc_in);
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        m.data = $urandom();
        m.due  = due;
        mem_q.push_back(m);
        last_due = due;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    d_rst = 1'b0; d_pc_valid = 1'b0; d_req_ready = 1'b1;
    d_id_ready = 1'b1; d_flush = 1'b0;
  endtask

  task automatic drain(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait for the next decode-visible entry and pin its PC.
  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (o_id_valid) begin
        seen = 1'b1;
        check(name, o_id_pc, exp_pc);
      end
    end
    check("first_valid_seen", {31'b0, seen}, 32'h1);
  endtask

  logic        sv  [12];
  logic [31:0] spc [12];
  logic        pr  [5];
  logic [31:0] pcv;
  int          acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    drop = 0;
    set_idle();
    d_rst = 1'b1; d_pc_valid = 1'b1; d_pc_in = 32'h40;
    rst = 1'b1; bus.pc_in = 32'h40; bus.pc_valid = 1'b1; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.flush = 1'b0; bus.id_ready = 1'b1;
    @(posedge clk); #1;

    // Reset: 2 cycles with pc_valid held high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pc_ready", o_pc_ready, 32'h0);
      check("rst_req_valid", o_req_valid, 32'h0);
    end
    set_idle();
    step();
    check("post_rst_id_valid", o_id_valid, 32'h0);
    check("post_rst_id_instr", o_id_instr, 32'h0000_0013);
    check("post_rst_id_pc", o_id_pc, 32'h0);

    // Streaming with 1-cycle memory
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 12; k++) begin
      d_pc_valid = (k < 8);
      d_pc_in    = 32'(4 * k);
      step();
      sv[k]  = o_id_valid;
      spc[k] = o_id_pc;
      if (k == 0) check("stream_first_accept", o_pc_ready, 32'h1);
    end
    check("stream_c0_invalid", sv[0], 32'h0);
    check("stream_c1_invalid", sv[1], 32'h0);
    for (int k = 2; k < 10; k++) begin
      check("stream_valid", sv[k], 32'h1);
      check("stream_pc", spc[k], 32'(4 * (k - 2)));
    end
    drain(6);

    // Full / backpressure
    set_idle();
    d_id_ready = 1'b0; d_pc_valid = 1'b1; pcv = 32'h1000;
    for (int k = 0; k < 5; k++) begin
      d_pc_in = pcv;
      step();
      pr[k] = o_pc_ready;
      if (m_accepted) pcv += 4;
    end
    for (int k = 0; k < 4; k++) check("full_accept", pr[k], 32'h1);
    check("full_5th_stalled", pr[4], 32'h0);
    d_id_ready = 1'b1; d_pc_in = pcv;
    step();
    check("pop_cycle_pc_ready", o_pc_ready, 32'h0);
    check("pop_cycle_head_pc", o_id_pc, 32'h1000);
    d_id_ready = 1'b0;
    step();
    check("after_pop_pc_ready", o_pc_ready, 32'h1);
    drain(12);

    // Flush with 3 requests in flight to slow memory
    set_idle();
    lat_min = 4; lat_max = 4;
    for (int k = 0; k < 3; k++) begin
      d_pc_valid = 1'b1; d_pc_in = 32'h2000 + 32'(4 * k);
      step();
      check("inflight_accept", o_pc_ready, 32'h1);
    end
    d_flush = 1'b1; d_pc_in = 32'h100;
    step();
    check("flush_cycle_pc_ready", o_pc_ready, 32'h0);
    d_flush = 1'b0; lat_min = 1; lat_max = 1;
    step();
    check("post_flush_accept", o_pc_ready, 32'h1);
    check("post_flush_id_valid", o_id_valid, 32'h0);
    d_pc_valid = 1'b0;
    wait_first("flush_first_pc", 32'h100);
    drain(8);

    // Flush coincident with a response and id_ready high
    set_idle();
    d_id_ready = 1'b0; d_pc_valid = 1'b1;
    lat_min = 1; lat_max = 1; d_pc_in = 32'h3000; step();
    lat_min = 3; lat_max = 3; d_pc_in = 32'h3004; step();
    d_pc_in = 32'h3008; step();
    d_pc_valid = 1'b0;
    for (int i = 0; i < 10 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); i++) step();
    d_flush = 1'b1; d_id_ready = 1'b1;
    step();
    check("coinc_head_valid", o_id_valid, 32'h1);
    check("coinc_head_pc", o_id_pc, 32'h3000);
    d_flush = 1'b0; d_pc_valid = 1'b1; d_pc_in = 32'h3100; lat_min = 1; lat_max = 1;
    step();
    check("coinc_after_id_valid", o_id_valid, 32'h0);
    check("coinc_after_accept", o_pc_ready, 32'h1);
    d_pc_valid = 1'b0;
    wait_first("coinc_first_pc", 32'h3100);
    drain(8);

    // Second flush while drop count is 2
    set_idle();
    lat_min = 6; lat_max = 6; d_pc_valid = 1'b1;
    d_pc_in = 32'h4000; step();
    d_pc_in = 32'h4004; step();
    d_pc_valid = 1'b0; d_flush = 1'b1; step();
    d_flush = 1'b0; d_pc_valid = 1'b1; d_pc_in = 32'h4008; step();
    check("accum_mid_accept", o_pc_ready, 32'h1);
    d_pc_valid = 1'b0; d_flush = 1'b1; step();
    d_flush = 1'b0; lat_min = 1; lat_max = 1;
    d_pc_valid = 1'b1; d_pc_in = 32'h4100; step();
    check("accum_accept_last_slot", o_pc_ready, 32'h1);
    d_pc_in = 32'h4104; step();
    check("accum_credit_exhausted", o_pc_ready, 32'h0);
    d_pc_valid = 1'b0;
    wait_first("accum_first_pc", 32'h4100);
    drain(10);

    // Wrap-around: 3*DEPTH+1 fetches, random id_ready/req_ready/latency
    set_idle();
    popped_pc.delete();
    lat_min = 1; lat_max = 4; acc = 0; pcv = 32'h5000;
    for (int i = 0; i < 600 && acc < 3 * DEPTH + 1; i++) begin
      d_pc_valid  = ($urandom_range(3, 0) != 0);
      d_pc_in     = pcv;
      d_id_ready  = $urandom_range(1, 0) != 0;
      d_req_ready = ($urandom_range(3, 0) != 0);
      step();
      if (m_accepted) begin acc++; pcv += 4; end
    end
    set_idle();
    for (int i = 0; i < 100 && popped_pc.size() < 3 * DEPTH + 1; i++) begin
      d_id_ready = $urandom_range(1, 0) != 0;
      step();
    end
    check("wrap_count", popped_pc.size(), 32'(3 * DEPTH + 1));
    for (int k = 0; k < popped_pc.size() && k < 3 * DEPTH + 1; k++)
      check("wrap_order", popped_pc[k], 32'h5000 + 32'(4 * k));
    drain(10);

    // Random traffic with occasional flushes and one mid-run reset
    for (int i = 0; i < 500; i++) begin
      d_rst       = (i == 250);
      d_pc_valid  = $urandom_range(1, 0) != 0;
      d_pc_in     = $urandom() & 32'hFFFF_FFFC;
      d_id_ready  = $urandom_range(3, 0) != 0;
      d_req_ready = $urandom_range(3, 0) != 0;
      d_flush     = ($urandom_range(15, 0) == 0);
      step();
    end
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
